// File: rtl/event_fragmenter.sv
// rtl/event_fragmenter.sv - cuts (addr,len)+64-bit event data into header-prefixed fragments
module event_fragmenter #(
    parameter int          FRAG_WORDS = 1024,
    parameter logic [15:0] MAGIC      = 16'h5045
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] s_ctrl_tdata,
    input  logic        s_ctrl_tvalid,
    output logic        s_ctrl_tready,
    input  logic [63:0] s_data_tdata,
    input  logic [7:0]  s_data_tkeep,
    input  logic        s_data_tlast,
    input  logic        s_data_tvalid,
    output logic        s_data_tready,
    output logic [63:0] m_frag_tdata,
    output logic [7:0]  m_frag_tkeep,
    output logic        m_frag_tlast,
    output logic        m_frag_tvalid,
    input  logic        m_frag_tready,
    output logic [1:0]  err_o,
    input  logic        err_clr_i,
    output logic [15:0] event_count_o
);

    // One spare bit in rem so a length close to 2^20 bytes cannot wrap to zero words.
    localparam int RW = 18;
    localparam int WW = 13;
    localparam logic [RW-1:0] FW_R = RW'(FRAG_WORDS);
    localparam logic [WW-1:0] FW_W = WW'(FRAG_WORDS);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [11:0]   addr_q, addr_d;
    logic [19:0]   len_q, len_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [14:0]   fnum_q, fnum_d;
    logic [63:0]   tdata_q, tdata_d;
    logic [7:0]    tkeep_q, tkeep_d;
    logic          tlast_q, tlast_d;
    logic          tvalid_q, tvalid_d;
    logic          final_q, final_d;
    logic [1:0]    err_q, err_d;
    logic [15:0]   count_q, count_d;

    logic          out_free, ctrl_fire, data_fire, hdr_load;
    logic [20:0]   len_sum;
    logic [RW-1:0] ctrl_rem;
    logic [11:0]   h_addr;
    logic [19:0]   h_len;
    logic [RW-1:0] h_rem;
    logic [14:0]   h_fnum;
    logic [1:0]    err_set;

    assign out_free      = !tvalid_q || m_frag_tready;
    assign s_ctrl_tready = (state_q == IDLE) && !areset;
    assign s_data_tready = ((state_q == PAYLOAD) && out_free) || (state_q == DRAIN);
    assign ctrl_fire     = s_ctrl_tvalid && s_ctrl_tready;
    assign data_fire     = s_data_tvalid && s_data_tready;
    assign len_sum       = {1'b0, s_ctrl_tdata[19:0]} + 21'd7;
    assign ctrl_rem      = len_sum[20:3];

    // The first header of an event is built straight from the incoming ctrl word so it is valid the next cycle.
    assign h_addr = (state_q == IDLE) ? s_ctrl_tdata[31:20] : addr_q;
    assign h_len  = (state_q == IDLE) ? s_ctrl_tdata[19:0]  : len_q;
    assign h_rem  = (state_q == IDLE) ? ctrl_rem            : rem_q;
    assign h_fnum = (state_q == IDLE) ? 15'd0               : fnum_q;
    assign hdr_load = out_free && (((state_q == IDLE) && ctrl_fire) || (state_q == HDR));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        rem_d    = rem_q;
        wcnt_d   = wcnt_q;
        fnum_d   = fnum_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q && !m_frag_tready;
        final_d  = final_q;
        err_set  = 2'b00;

        case (state_q)
            IDLE: begin
                if (ctrl_fire) begin
                    addr_d  = s_ctrl_tdata[31:20];
                    len_d   = s_ctrl_tdata[19:0];
                    rem_d   = ctrl_rem;
                    fnum_d  = 15'd0;
                    state_d = HDR;
                end
            end
            PAYLOAD: begin
                if (data_fire) begin
                    tdata_d  = s_data_tdata;
                    tkeep_d  = ((rem_q == RW'(1)) || s_data_tlast) ? s_data_tkeep : 8'hFF;
                    tlast_d  = (wcnt_q == WW'(1)) || s_data_tlast;
                    tvalid_d = 1'b1;
                    final_d  = 1'b0;
                    rem_d    = rem_q - RW'(1);
                    wcnt_d   = wcnt_q - WW'(1);
                    if (s_data_tlast) begin
                        final_d    = 1'b1;
                        err_set[0] = (rem_q > RW'(1));
                        state_d    = IDLE;
                    end else if (rem_q == RW'(1)) begin
                        final_d    = 1'b1;
                        err_set[1] = 1'b1;
                        state_d    = DRAIN;
                    end else if (wcnt_q == WW'(1)) begin
                        fnum_d  = fnum_q + 15'd1;
                        state_d = HDR;
                    end
                end
            end
            DRAIN: begin
                if (data_fire && s_data_tlast) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        if (hdr_load) begin
            tdata_d  = {MAGIC, h_addr, h_len, (h_rem <= FW_R), h_fnum};
            tkeep_d  = 8'hFF;
            tlast_d  = (h_rem == '0);
            tvalid_d = 1'b1;
            final_d  = (h_rem == '0);
            if (h_rem == '0) begin
                state_d = IDLE;
            end else begin
                state_d = PAYLOAD;
                wcnt_d  = (h_rem < FW_R) ? WW'(h_rem) : FW_W;
            end
        end

        err_d   = (err_clr_i ? 2'b00 : err_q) | err_set;
        count_d = count_q;
        if (tvalid_q && m_frag_tready && final_q) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            rem_q    <= '0;
            wcnt_q   <= '0;
            fnum_q   <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            final_q  <= 1'b0;
            err_q    <= 2'b00;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            wcnt_q   <= wcnt_d;
            fnum_q   <= fnum_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
            final_q  <= final_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    assign m_frag_tdata  = tdata_q;
    assign m_frag_tkeep  = tkeep_q;
    assign m_frag_tlast  = tlast_q;
    assign m_frag_tvalid = tvalid_q;
    assign err_o         = err_q;
    assign event_count_o = count_q;

endmodule
